// File: rtl/rvcpu_pkg.sv
// rtl/rvcpu_pkg.sv - shared types, funct3 encodings and helpers for the memory stage
//
// Contents:
//   Width        default datapath / address width
//   F3_*         RISC-V load/store funct3 encodings
//   mem_op_t     {store, funct3} memory operation
//   mem_state_t  memory-stage FSM states (IDLE, REQ, RESP, HOLD)
//   mem_size_t   decoded access size
//   stage_ex_t   EX -> MEM payload
//   stage_mem_t  MEM -> WB payload
//   mem_size()   funct3 -> access size (reserved encodings map to word)
//   misaligned() true when an access is not naturally aligned
package rvcpu;

    localparam int Width = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic       store;
        logic [2:0] funct3;
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } mem_state_t;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic [Width-1:0] pc;
        logic [Width-1:0] data;
        logic [4:0]       rd;
        logic             rd_valid;
        logic             is_mem;
        mem_op_t          op;
        logic [Width-1:0] addr;
    } stage_ex_t;

    typedef struct packed {
        logic [Width-1:0] pc;
        logic [4:0]       rd;
        logic             rd_valid;
        logic [Width-1:0] data;
    } stage_mem_t;

    // Signedness lives in funct3[2]; only the size matters here, so the
    // reserved encodings (011, 110, 111) fall through to a full word.
    function automatic mem_size_t mem_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SIZE_B;
            F3_H, F3_HU: return SIZE_H;
            default:     return SIZE_W;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (mem_size(funct3))
            SIZE_B:  return 1'b0;
            SIZE_H:  return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/stage_mem_align.sv
// rtl/stage_mem_align.sv - combinational store lane/byte-enable generation and load extract/extend
//
// Module mem_align, parameter Width (bus width in bits).
// Ports:
//   funct3     in   access size / signedness
//   addr_lo    in   byte offset within the bus word
//   wdata      in   store data (value in the low lanes)
//   wdata_lane out  store data replicated across all lanes
//   be         out  store byte enables
//   rdata      in   raw bus word returned by a load
//   rdata_ext  out  selected and sign/zero-extended load value
// Low offset bits that would break natural alignment are ignored, so a
// misaligned request is silently truncated to its aligned container.
module mem_align
    import rvcpu::*;
#(
    parameter int Width = rvcpu::Width
) (
    input  logic [2:0]         funct3,
    input  logic [1:0]         addr_lo,
    input  logic [Width-1:0]   wdata,
    output logic [Width-1:0]   wdata_lane,
    output logic [Width/8-1:0] be,
    input  logic [Width-1:0]   rdata,
    output logic [Width-1:0]   rdata_ext
);

    localparam logic [Width/8-1:0] BE_B = {{(Width/8-1){1'b0}}, 1'b1};
    localparam logic [Width/8-1:0] BE_H = {{(Width/8-2){1'b0}}, 2'b11};

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        wdata_lane = wdata;
        be         = '1;
        rdata_ext  = rdata;
        byte_v     = rdata[{addr_lo, 3'b000} +: 8];
        half_v     = rdata[{addr_lo[1], 4'b0000} +: 16];

        case (mem_size(funct3))
            SIZE_B: begin
                wdata_lane = {(Width/8){wdata[7:0]}};
                be         = BE_B << addr_lo;
                rdata_ext  = funct3[2] ? {{(Width-8){1'b0}}, byte_v}
                                       : {{(Width-8){byte_v[7]}}, byte_v};
            end
            SIZE_H: begin
                wdata_lane = {(Width/16){wdata[15:0]}};
                be         = BE_H << {addr_lo[1], 1'b0};
                rdata_ext  = funct3[2] ? {{(Width-16){1'b0}}, half_v}
                                       : {{(Width-16){half_v[15]}}, half_v};
            end
            default: begin
                wdata_lane = wdata;
                be         = '1;
                rdata_ext  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// rtl/stage_mem.sv - pipeline memory stage: ALU pass-through, load/store data-bus master
//
// Optional feature: define RVCPU_MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses instead of truncating the address to natural alignment.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in, in_valid, in_ready   EX result handshake (accepted only in IDLE)
//   dbus_req/we/addr/wdata/be  data-bus request, held until dbus_gnt
//   dbus_gnt                 request accepted
//   dbus_rvalid, dbus_rdata  load response
//   out, out_valid, out_ready  WB handshake
//   trap                     misaligned access flag, valid with out_valid
module stage_mem
    import rvcpu::*;
#(
    parameter int Width = rvcpu::Width
) (
    input  logic                clk,
    input  logic                rst,
    input  rvcpu::stage_ex_t    in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                dbus_req,
    output logic                dbus_we,
    output logic [Width-1:0]    dbus_addr,
    output logic [Width-1:0]    dbus_wdata,
    output logic [Width/8-1:0]  dbus_be,
    input  logic                dbus_gnt,
    input  logic                dbus_rvalid,
    input  logic [Width-1:0]    dbus_rdata,
    output rvcpu::stage_mem_t   out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                trap
);

    mem_state_t       state;
    mem_state_t       state_next;

    mem_op_t          op_q;
    logic [Width-1:0] addr_q;
    logic [Width-1:0] data_q;
    logic             rd_valid_q;
    stage_mem_t       out_q;

    logic [Width-1:0] rdata_ext;
    logic             in_mis;

`ifdef RVCPU_MISALIGN_TRAP_EN
    logic trap_q;
    assign in_mis = in.is_mem && misaligned(in.op.funct3, in.addr[1:0]);
    assign trap   = trap_q;
`else
    assign in_mis = 1'b0;
    assign trap   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!in.is_mem || in_mis) begin
                        state_next = HOLD;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (dbus_gnt) begin
                    state_next = op_q.store ? HOLD : RESP;
                end
            end
            RESP: begin
                if (dbus_rvalid) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory ops start with rd_valid cleared: stores and trapped accesses
    // never write back, and a load only sets it when its data arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            out_q      <= '0;
`ifdef RVCPU_MISALIGN_TRAP_EN
            trap_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q           <= in.op;
                        addr_q         <= in.addr;
                        data_q         <= in.data;
                        rd_valid_q     <= in.rd_valid;
                        out_q.pc       <= in.pc;
                        out_q.rd       <= in.rd;
                        out_q.data     <= in.data;
                        out_q.rd_valid <= in.is_mem ? 1'b0 : in.rd_valid;
`ifdef RVCPU_MISALIGN_TRAP_EN
                        trap_q         <= in_mis;
`endif
                    end
                end
                RESP: begin
                    if (dbus_rvalid) begin
                        out_q.data     <= rdata_ext;
                        out_q.rd_valid <= rd_valid_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    mem_align #(
        .Width (Width)
    ) u_align (
        .funct3     (op_q.funct3),
        .addr_lo    (addr_q[1:0]),
        .wdata      (data_q),
        .wdata_lane (dbus_wdata),
        .be         (dbus_be),
        .rdata      (dbus_rdata),
        .rdata_ext  (rdata_ext)
    );

    assign in_ready  = (state == IDLE);
    assign dbus_req  = (state == REQ);
    assign dbus_we   = dbus_req & op_q.store;
    assign dbus_addr = {addr_q[Width-1:2], 2'b00};
    assign out_valid = (state == HOLD);
    assign out       = out_q;

endmodule

// File: tb/tb_stage_mem.sv
// tb/tb_stage_mem.sv - directed self-checking bench for stage_mem with an expected-result scoreboard
module tb_stage_mem;
    import rvcpu::*;

    logic        clk = 1'b0;
    logic        rst;
    stage_ex_t   in_s;
    logic        in_valid;
    logic        in_ready;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    stage_mem_t  out_s;
    logic        out_valid;
    logic        out_ready;
    logic        trap;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rv;
        logic [31:0] data;
        logic        trap;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    stage_mem #(.Width(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in_s),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dbus_req    (dbus_req),
        .dbus_we     (dbus_we),
        .dbus_addr   (dbus_addr),
        .dbus_wdata  (dbus_wdata),
        .dbus_be     (dbus_be),
        .dbus_gnt    (dbus_gnt),
        .dbus_rvalid (dbus_rvalid),
        .dbus_rdata  (dbus_rdata),
        .out         (out_s),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rd, input logic rv,
                         input logic is_mem, input logic store, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        in_s.pc        = pc;
        in_s.rd        = rd;
        in_s.rd_valid  = rv;
        in_s.is_mem    = is_mem;
        in_s.op.store  = store;
        in_s.op.funct3 = f3;
        in_s.addr      = addr;
        in_s.data      = data;
        in_valid       = 1'b1;
    endtask

    // Waits (bounded) for out_valid, compares against the scoreboard head, then retires it.
    task automatic consume(input string tag);
        exp_t e;
        int   n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
        end
        if (sb.size() > 0 && out_valid === 1'b1) begin
            e = sb.pop_front();
            chk({tag, "_pc"}, out_s.pc, e.pc);
            chk({tag, "_rd"}, {27'd0, out_s.rd}, {27'd0, e.rd});
            chk({tag, "_rd_valid"}, {31'd0, out_s.rd_valid}, {31'd0, e.rv});
            chk({tag, "_trap"}, {31'd0, trap}, {31'd0, e.trap});
            if (e.rv) chk({tag, "_data"}, out_s.data, e.data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic mem_access(input string tag, input logic [31:0] pc, input logic store,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] rdata,
                              input logic [31:0] exp_data, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_addr,
                              input int gnt_wait, input int rv_wait);
        drive(pc, 5'd9, 1'b1, 1'b1, store, f3, addr, data);
        sb.push_back('{pc: pc, rd: 5'd9, rv: !store, data: exp_data, trap: 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_req"}, {31'd0, dbus_req}, 32'd1);
        chk({tag, "_addr"}, dbus_addr, exp_addr);
        chk({tag, "_we"}, {31'd0, dbus_we}, {31'd0, store});
        if (store) begin
            chk({tag, "_be"}, {28'd0, dbus_be}, {28'd0, exp_be});
            chk({tag, "_wdata"}, dbus_wdata, exp_wdata);
        end
        repeat (gnt_wait) begin
            @(negedge clk);
            chk({tag, "_req_hold"}, {31'd0, dbus_req}, 32'd1);
            chk({tag, "_addr_hold"}, dbus_addr, exp_addr);
        end
        dbus_gnt = 1'b1;
        @(negedge clk);
        dbus_gnt = 1'b0;
        if (!store) begin
            chk({tag, "_resp_noreq"}, {31'd0, dbus_req}, 32'd0);
            repeat (rv_wait) @(negedge clk);
            dbus_rvalid = 1'b1;
            dbus_rdata  = rdata;
            @(negedge clk);
            dbus_rvalid = 1'b0;
            dbus_rdata  = 32'h0;
        end
        consume(tag);
    endtask

    initial begin
        rst         = 1'b1;
        in_s        = '0;
        in_valid    = 1'b0;
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'h0;
        out_ready   = 1'b0;
        #1;
        chk("rst_req", {31'd0, dbus_req}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_rd_valid", {31'd0, out_s.rd_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ALU pass-through, latency one
        drive(32'h10, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h1234);
        sb.push_back('{pc: 32'h10, rd: 5'd5, rv: 1'b1, data: 32'h1234, trap: 1'b0});
        chk("alu_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("alu_latency", {31'd0, out_valid}, 32'd1);
        consume("alu");
        chk("alu_back_idle", {31'd0, in_ready}, 32'd1);

        // LB 0x103, gnt two cycles late, rvalid three cycles after gnt
        mem_access("lb", 32'h20, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF,
                   32'hFFFF_FF80, 4'h0, 32'h0, 32'h100, 2, 2);
        // SH 0x202
        mem_access("sh", 32'h24, 1'b1, 3'b001, 32'h202, 32'hABCD, 32'h0,
                   32'h0, 4'b1100, 32'hABCD_ABCD, 32'h200, 0, 0);
        mem_access("sb", 32'h28, 1'b1, 3'b000, 32'h301, 32'h5A, 32'h0,
                   32'h0, 4'b0010, 32'h5A5A_5A5A, 32'h300, 1, 0);
        mem_access("sw", 32'h2C, 1'b1, 3'b010, 32'h400, 32'h1122_3344, 32'h0,
                   32'h0, 4'b1111, 32'h1122_3344, 32'h400, 0, 0);
        mem_access("lh", 32'h30, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF,
                   32'hFFFF_8001, 4'h0, 32'h0, 32'h100, 0, 0);
        mem_access("lhu", 32'h34, 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_7FFF,
                   32'h0000_8001, 4'h0, 32'h0, 32'h100, 0, 1);
        mem_access("lbu", 32'h38, 1'b0, 3'b100, 32'h101, 32'h0, 32'h1234_F678,
                   32'h0000_00F6, 4'h0, 32'h0, 32'h100, 0, 0);
        mem_access("lw_rsvd", 32'h3C, 1'b0, 3'b011, 32'h10, 32'h0, 32'h89AB_CDEF,
                   32'h89AB_CDEF, 4'h0, 32'h0, 32'h10, 0, 0);

        // Misaligned LW 0x101
`ifdef RVCPU_MISALIGN_TRAP_EN
        drive(32'h40, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
        sb.push_back('{pc: 32'h40, rd: 5'd9, rv: 1'b0, data: 32'h0, trap: 1'b1});
        @(negedge clk);
        in_valid = 1'b0;
        chk("mis_noreq", {31'd0, dbus_req}, 32'd0);
        chk("mis_trap", {31'd0, trap}, 32'd1);
        consume("mis");
`else
        mem_access("mis", 32'h40, 1'b0, 3'b010, 32'h101, 32'h0, 32'hDEAD_BEEF,
                   32'hDEAD_BEEF, 4'h0, 32'h0, 32'h100, 0, 0);
`endif

        // Back-pressure: hold out_ready low five cycles with a new instruction waiting
        drive(32'h50, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h5555);
        sb.push_back('{pc: 32'h50, rd: 5'd3, rv: 1'b1, data: 32'h5555, trap: 1'b0});
        @(negedge clk);
        drive(32'h54, 5'd4, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h6666);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_pc", out_s.pc, sb[0].pc);
            chk("bp_data", out_s.data, sb[0].data);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        void'(sb.pop_front());
        chk("bp_release_idle", {31'd0, in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        sb.push_back('{pc: 32'h54, rd: 5'd4, rv: 1'b1, data: 32'h6666, trap: 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_latency", {31'd0, out_valid}, 32'd1);
        consume("bp_next");

        // Reset during RESP followed by a stray rvalid
        drive(32'h70, 5'd6, 1'b1, 1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        dbus_gnt = 1'b1;
        @(negedge clk);
        dbus_gnt = 1'b0;
        chk("rr_in_resp", {31'd0, dbus_req}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rr_req", {31'd0, dbus_req}, 32'd0);
        chk("rr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rr_trap", {31'd0, trap}, 32'd0);
        chk("rr_rd_valid", {31'd0, out_s.rd_valid}, 32'd0);
        chk("rr_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'hFEED_FACE;
        @(negedge clk);
        dbus_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rr_stray_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rr_stray_in_ready", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
        end

        // Stage still works after the aborted transaction
        drive(32'h80, 5'd8, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'hC0DE);
        sb.push_back('{pc: 32'h80, rd: 5'd8, rv: 1'b1, data: 32'hC0DE, trap: 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        consume("post_rst");
        chk("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
